// File: rtl/pe_load_sequencer.sv
// Initiator for one processing element: fetches an A row and B column from a
// 2-cycle-latency word memory, runs L MAC cycles and writes the dot product back.
module pe_load_sequencer #(
  parameter int N      = 16,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [1:0]        DIMEN,
  input  logic [ADDR_W-1:0] BASE_A,
  input  logic [ADDR_W-1:0] BASE_B,
  input  logic [ADDR_W-1:0] BASE_C,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [31:0]       MEM_RDATA,
  output logic              MEM_WR,
  output logic [31:0]       MEM_WDATA,
  output logic [2:0]        LATENCY_COUNTER,
  output logic              RST_ADD,
  output logic              RST_ACC,
  output logic              RST_PC,
  output logic              MAT_MUX,
  output logic              WRITE_MAT,
  output logic              MAC_CTRL,
  output logic              OUT_READY,
  output logic [31:0]       PE_DATAIN,
  output logic [1:0]        PE_DIMEN,
  input  logic [31:0]       PE_DATAOUT
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_A, S_SWAP, S_LOAD_B, S_MAC, S_WRITE, S_FIN
  } state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_idx, w_idx_nxt;
  logic [1:0]        r_lat, w_lat_nxt;
  logic [1:0]        r_dimen;
  logic [ADDR_W-1:0] r_base_a, r_base_b, r_base_c;
  logic              w_latch;
  logic [CW-1:0]     w_len;
  logic              w_last;
  logic              w_load;

  assign w_len  = CW'(2) << r_dimen;
  assign w_last = (r_idx == w_len - CW'(1));
  assign w_load = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_lat    <= '0;
      r_dimen  <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      r_lat   <= w_lat_nxt;
      if (w_latch) begin
        r_dimen  <= DIMEN;
        r_base_a <= BASE_A;
        r_base_b <= BASE_B;
        r_base_c <= BASE_C;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_idx_nxt       = r_idx;
    w_lat_nxt       = r_lat;
    w_latch         = 1'b0;
    BUSY            = (r_state != S_IDLE) && (r_state != S_FIN);
    DONE            = 1'b0;
    MEM_ADDR        = '0;
    MEM_RD          = 1'b0;
    MEM_WR          = 1'b0;
    MEM_WDATA       = '0;
    LATENCY_COUNTER = '0;
    RST_ADD         = 1'b0;
    RST_ACC         = 1'b0;
    RST_PC          = 1'b0;
    MAT_MUX         = 1'b0;
    WRITE_MAT       = 1'b0;
    MAC_CTRL        = 1'b0;
    OUT_READY       = 1'b0;
    PE_DATAIN       = '0;
    PE_DIMEN        = BUSY ? r_dimen : 2'd0;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_latch = 1'b1;
          w_next  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        RST_ADD   = 1'b1;
        RST_ACC   = 1'b1;
        RST_PC    = 1'b1;
        w_idx_nxt = '0;
        w_lat_nxt = '0;
        w_next    = S_LOAD_A;
      end
      S_LOAD_A, S_LOAD_B: begin
        WRITE_MAT       = 1'b1;
        MAT_MUX         = (r_state == S_LOAD_A);
        LATENCY_COUNTER = {1'b0, r_lat};
        // Issue at lat 0; the word comes back two cycles later at lat 2.
        if (r_lat == 2'd0) begin
          MEM_RD   = 1'b1;
          MEM_ADDR = ((r_state == S_LOAD_A) ? r_base_a : r_base_b) + ADDR_W'(r_idx);
        end
        if (r_lat == 2'd2) begin
          PE_DATAIN = MEM_RDATA;
          w_lat_nxt = '0;
          if (w_last) begin
            w_idx_nxt = '0;
            w_next    = (r_state == S_LOAD_A) ? S_SWAP : S_MAC;
          end else begin
            w_idx_nxt = r_idx + CW'(1);
          end
        end else begin
          w_lat_nxt = r_lat + 2'd1;
        end
      end
      S_SWAP: begin
        RST_ADD   = 1'b1;
        w_idx_nxt = '0;
        w_lat_nxt = '0;
        w_next    = S_LOAD_B;
      end
      S_MAC: begin
        // MAC length is counted here; the PE's own done flag cannot reach 16.
        MAC_CTRL = 1'b1;
        if (w_last) begin
          w_idx_nxt = '0;
          w_next    = S_WRITE;
        end else begin
          w_idx_nxt = r_idx + CW'(1);
        end
      end
      S_WRITE: begin
        OUT_READY = 1'b1;
        MEM_WR    = 1'b1;
        MEM_ADDR  = r_base_c;
        MEM_WDATA = PE_DATAOUT;
        w_next    = S_FIN;
      end
      S_FIN: begin
        DONE   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
